// File: rtl/req_router_queue.sv
// Request router: steers each incoming request by opcode into one of NCH
// independent first-word-fall-through queues. Requests whose opcode does not
// name a channel are accepted, dropped, and reported with a one-cycle pulse.
module req_router_queue #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int NCH     = 2,
  parameter int QDEPTH  = 16,
  localparam int INSTRW = 3*ADDRW + OPCODEW,
  localparam int PTRW   = $clog2(QDEPTH),
  localparam int CNTW   = PTRW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [OPCODEW-1:0]    opcode,
  input  logic [ADDRW-1:0]      key_addr,
  input  logic [ADDRW-1:0]      text_addr,
  input  logic [ADDRW-1:0]      dest_addr,
  input  logic                  flush,
  output logic [NCH*INSTRW-1:0] instr_out,
  output logic [NCH-1:0]        valid_out,
  input  logic [NCH-1:0]        ready_out,
  output logic [NCH*CNTW-1:0]   count,
  output logic                  err_illegal
);

  logic [INSTRW-1:0] entry;
  logic [NCH-1:0]    hit;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    push;
  logic              legal;
  logic              sel_full;
  logic              accept;
  logic              err_illegal_reg;

  assign entry    = {opcode, key_addr, text_addr, dest_addr};
  // An opcode is legal exactly when it matches one of the channel indices.
  assign legal    = |hit;
  assign sel_full = |(hit & full);
  // Illegal requests are always taken (and dropped); legal ones wait for room.
  assign ready_in = !flush && (!legal || !sel_full);
  assign accept   = valid_in && ready_in;
  assign err_illegal = err_illegal_reg;

  // Flag a dropped illegal request for the cycle after it was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal_reg <= 1'b0;
    end else begin
      err_illegal_reg <= accept && !legal;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [INSTRW-1:0] mem [QDEPTH];
      logic [PTRW-1:0]   wr_ptr_reg, wr_ptr_next;
      logic [PTRW-1:0]   rd_ptr_reg, rd_ptr_next;
      logic [CNTW-1:0]   count_reg, count_next;
      logic              pop;

      assign hit[gi]  = (opcode == OPCODEW'(gi));
      // A same-cycle pop never frees a slot for a push: full uses the
      // registered count only.
      assign full[gi] = (count_reg == CNTW'(QDEPTH));
      assign push[gi] = accept && hit[gi];
      assign pop      = (count_reg != '0) && ready_out[gi] && !flush;

      assign valid_out[gi]                 = (count_reg != '0);
      assign count[gi*CNTW +: CNTW]        = count_reg;
      assign instr_out[gi*INSTRW +: INSTRW] = mem[rd_ptr_reg];

      // Pointer and occupancy update; flush wins over any push or pop.
      always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
          wr_ptr_next = '0;
          rd_ptr_next = '0;
          count_next  = '0;
        end else begin
          if (push[gi]) wr_ptr_next = wr_ptr_reg + PTRW'(1);
          if (pop)      rd_ptr_next = rd_ptr_reg + PTRW'(1);
          case ({push[gi], pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
          endcase
        end
      end

      // Queue state; reset empties the channel without touching storage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
          count_reg  <= count_next;
        end
      end

      // Entry storage written at the write pointer on every accepted push.
      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= entry;
      end
    end
  endgenerate

endmodule
